// File: rtl/pio_bcd_hex_if.sv
// pio_bcd_hex_if: groups the PIO value and display outputs of pio_bcd_hex.
//   value_in     : binary value from the PIO conduit (readdata)
//   hex_out      : packed 7-segment codes, digit k in [7k+6:7k]
//   bcd_out      : last converted BCD value, digit k in [4k+3:4k]
//   busy         : converter is in CONVERT or LOAD
//   update_pulse : one-cycle strobe when hex_out/bcd_out change
// master = PIO side (drives value_in), slave = converter.
`timescale 1ns/1ps
interface pio_bcd_hex_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0]    value_in;
  logic [7*DIGITS-1:0] hex_out;
  logic [4*DIGITS-1:0] bcd_out;
  logic                busy;
  logic                update_pulse;

  modport master (
    output value_in,
    input  hex_out, bcd_out, busy, update_pulse
  );

  modport slave (
    input  value_in,
    output hex_out, bcd_out, busy, update_pulse
  );
endinterface

// File: rtl/pio_bcd_hex.sv
// pio_bcd_hex: watches the PIO output value and shows it in decimal on the
// DE1 HEX displays. Conversion uses a sequential double-dabble engine, one
// shift per clock. Same clock domain as the PIO, so no synchronizer.
//
// Ports:
//   clk    : system clock (CLOCK_50)
//   reset  : synchronous, active-high
//   pio    : pio_bcd_hex_if.slave (value_in, hex_out, bcd_out, busy,
//            update_pulse)
//
// Parameters: WIDTH (4..10), DIGITS (must hold 2**WIDTH-1), ACTIVE_LOW
// (1 = segment on drives 0).
//
// Optional macro PIO_BCD_HEX_LZB_EN: leading-zero blanking of digits 1 and up.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | compare in_q against last_q, start a conversion on change
// CONVERT | one double-dabble iteration per cycle, WIDTH iterations
// LOAD    | register BCD/segment outputs and pulse update_pulse
`timescale 1ns/1ps
module pio_bcd_hex #(
  parameter int WIDTH      = 8,
  parameter int DIGITS     = 3,
  parameter int ACTIVE_LOW = 1
) (
  input logic         clk,
  input logic         reset,
  pio_bcd_hex_if.slave pio
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int HEX_W = 7 * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 4 || WIDTH > 10) begin : g_bad_width
    $error("pio_bcd_hex: WIDTH must be in 4..10");
  end
  if ((2 ** WIDTH) - 1 >= 10 ** DIGITS) begin : g_bad_digits
    $error("pio_bcd_hex: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  in_q;
  logic [WIDTH-1:0]  last_q;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_adj;
  logic [CNT_W-1:0]  cnt;
  logic [BCD_W-1:0]  bcd_q;
  logic [HEX_W-1:0]  hex_q;
  logic              pulse_q;
  logic              start, step, load, busy_c;

  // Segment code in active-low g..a order; nibbles above 9 show blank.
  function automatic logic [6:0] seg_code(input logic [3:0] d, input logic blank);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      default: c = 7'h7F;
    endcase
    if (blank) c = 7'h7F;
    return (ACTIVE_LOW != 0) ? c : ~c;
  endfunction

  function automatic logic [HEX_W-1:0] encode(input logic [BCD_W-1:0] bcd);
    logic [HEX_W-1:0] h;
`ifdef PIO_BCD_HEX_LZB_EN
    logic upper_zero;
    upper_zero = 1'b1;
`endif
    h = '0;
    // Walk from the most significant digit so upper_zero means "this digit
    // and everything above it is zero".
    for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef PIO_BCD_HEX_LZB_EN
      upper_zero = upper_zero && (bcd[4*k +: 4] == 4'd0);
      h[7*k +: 7] = seg_code(bcd[4*k +: 4], upper_zero && (k != 0));
`else
      h[7*k +: 7] = seg_code(bcd[4*k +: 4], 1'b0);
`endif
    end
    return h;
  endfunction

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < DIGITS; k++) begin
      if (sr[WIDTH + 4*k +: 4] >= 4'd5)
        sr_adj[WIDTH + 4*k +: 4] = sr[WIDTH + 4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    step       = 1'b0;
    load       = 1'b0;
    busy_c     = 1'b0;
    case (state)
      IDLE: begin
        if (in_q != last_q) begin
          start      = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        step   = 1'b1;
        busy_c = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_next = LOAD;
      end
      LOAD: begin
        load       = 1'b1;
        busy_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q    <= '0;
      last_q  <= '0;
      sr      <= '0;
      cnt     <= '0;
      bcd_q   <= '0;
      hex_q   <= encode('0);
      pulse_q <= 1'b0;
    end else begin
      in_q    <= pio.value_in;
      pulse_q <= 1'b0;
      if (start) begin
        last_q <= in_q;
        sr     <= {{BCD_W{1'b0}}, in_q};
        cnt    <= '0;
      end
      if (step) begin
        sr  <= {sr_adj[SR_W-2:0], 1'b0};
        cnt <= cnt + CNT_W'(1);
      end
      if (load) begin
        bcd_q   <= sr[SR_W-1 -: BCD_W];
        hex_q   <= encode(sr[SR_W-1 -: BCD_W]);
        pulse_q <= 1'b1;
      end
    end
  end

  assign pio.bcd_out      = bcd_q;
  assign pio.hex_out      = hex_q;
  assign pio.busy         = busy_c;
  assign pio.update_pulse = pulse_q;

endmodule

// File: tb/tb_pio_bcd_hex.sv
// Testbench for pio_bcd_hex: directed scenarios plus random values, checked
// by a scoreboard fed from a decimal reference model.
`timescale 1ns/1ps
module tb_pio_bcd_hex;

  localparam int W = 8;
  localparam int D = 3;

  logic clk;
  logic reset;

  pio_bcd_hex_if #(.WIDTH(W), .DIGITS(D)) pio ();

  pio_bcd_hex #(.WIDTH(W), .DIGITS(D), .ACTIVE_LOW(1)) dut (
    .clk   (clk),
    .reset (reset),
    .pio   (pio)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    logic [20:0] hex;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   shown    = 0;
  bit   lax      = 1'b0;
  int   lax_pulses = 0;

  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

`ifdef PIO_BCD_HEX_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  function automatic logic [11:0] m_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [20:0] m_hex(input int v);
    logic [20:0] h;
    int p;
    h = '0;
    p = 1;
    for (int k = 0; k < D; k++) begin
      // A digit is a leading zero when the number is shorter than k+1 digits.
      if (LZB && k > 0 && v < p) h[7*k +: 7] = 7'h7F;
      else                       h[7*k +: 7] = seg_tab[(v / p) % 10];
      p = p * 10;
    end
    return h;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every update_pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!reset && pio.update_pulse === 1'b1) begin
      if (lax) begin
        lax_pulses++;
      end else if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_update actual bcd=%h expected no pulse (cycle %0d)",
                 pio.bcd_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("upd_bcd", 32'(pio.bcd_out), 32'(e.bcd));
        chk("upd_hex", 32'(pio.hex_out), 32'(e.hex));
        if (e.due >= 0) chk("upd_latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Drive a new PIO value; expect an update only if it differs from what is
  // currently displayed. A timed value must be issued while the DUT is idle.
  task automatic put(input int v, input bit timed);
    exp_t e;
    @(negedge clk);
    pio.value_in = W'(v);
    if (v != shown) begin
      e.bcd = m_bcd(v);
      e.hex = m_hex(v);
      e.due = timed ? cyc + W + 3 : -1;
      sb.push_back(e);
      shown = v;
    end
  endtask

  task automatic check_idle_outputs(input string tag, input int v);
    chk({tag, "_bcd"},   32'(pio.bcd_out), 32'(m_bcd(v)));
    chk({tag, "_hex"},   32'(pio.hex_out), 32'(m_hex(v)));
    chk({tag, "_busy"},  32'(pio.busy), 32'(0));
    chk({tag, "_pulse"}, 32'(pio.update_pulse), 32'(0));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    reset = 1'b1;
    pio.value_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset", 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_busy", 32'(pio.busy), 32'(0));

    // 0 -> 255: busy rises after E1, update after E10.
    put(255, 1'b1);
    @(negedge clk);
    chk("busy_after_e0", 32'(pio.busy), 32'(0));
    @(negedge clk);
    chk("busy_after_e1", 32'(pio.busy), 32'(1));
    repeat (12) @(negedge clk);
    chk("busy_done", 32'(pio.busy), 32'(0));

    // Change during conversion: 100 then 37 three cycles later.
    put(100, 1'b1);
    repeat (2) @(negedge clk);
    put(37, 1'b0);
    repeat (30) @(negedge clk);
    chk("final_37_bcd", 32'(pio.bcd_out), 32'h037);

    // Reset in the middle of converting 200.
    @(negedge clk);
    pio.value_in = W'(200);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset", 0);
    reset = 1'b0;
    shown = 0;
    begin
      exp_t e;
      e.bcd = m_bcd(200);
      e.hex = m_hex(200);
      e.due = cyc + W + 3;
      sb.push_back(e);
      shown = 200;
    end
    repeat (15) @(negedge clk);

    // Same value written twice gives one update.
    put(42, 1'b1);
    repeat (15) @(negedge clk);
    put(42, 1'b1);
    repeat (15) @(negedge clk);
    chk("repeat_42_bcd", 32'(pio.bcd_out), 32'h042);

    // Values that exercise leading-zero handling.
    put(7, 1'b1);
    repeat (15) @(negedge clk);
    put(0, 1'b1);
    repeat (15) @(negedge clk);
    put(105, 1'b1);
    repeat (15) @(negedge clk);

    // Random held values, some repeated.
    for (int i = 0; i < 40; i++) begin
      v = ($urandom_range(0, 3) == 0) ? shown : int'($urandom_range(0, 255));
      put(v, 1'b1);
      repeat (W + 3 + $urandom_range(0, 4)) @(negedge clk);
    end

    // Burst of fast changes: intermediate updates are unconstrained, the
    // settled value must end up displayed.
    lax = 1'b1;
    v = 0;
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 255));
      @(negedge clk);
      pio.value_in = W'(v);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    lax = 1'b0;
    shown = v;
    check_idle_outputs("burst_settled", v);

    put(int'($urandom_range(0, 255)), 1'b1);
    repeat (15) @(negedge clk);

    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
